mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester data-memory arbiter with loader anti-starvation
//
// Purpose:
//   Shares one single-port data memory between the CPU pipeline (p_*) and a
//   loader (l_*). Each access takes an arbitration edge, one ISSUE cycle
//   (memory strobed, grant pulsed) and one COMPLETE cycle (done pulsed, load
//   data returned). COMPLETE also arbitrates, so back-to-back accesses run at
//   one access per two cycles. The pipeline normally wins ties. After
//   STARVE_LIMIT consecutive pipeline wins while the loader waits, the loader
//   is forced through.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   p_req/p_we            pipeline request and write enable (1 = store)
//   p_addr/p_wdata        pipeline address and store data
//   p_gnt/p_done          pipeline grant pulse (ISSUE), completion pulse (COMPLETE)
//   p_rdata               pipeline load data (valid with p_done, else 0)
//   l_*                   loader port, same meaning as p_*
//   mem_en/mem_we         data-memory enable and write strobe
//   mem_addr/mem_wdata    data-memory address and write data
//   mem_rdata             data-memory read data, one cycle after a read strobe
//   stall                 pipeline stall request = p_req & ~p_done

module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_req,
  input  logic        p_we,
  input  logic [15:0] p_addr,
  input  logic [15:0] p_wdata,
  output logic        p_gnt,
  output logic        p_done,
  output logic [15:0] p_rdata,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [15:0] l_addr,
  input  logic [15:0] l_wdata,
  output logic        l_gnt,
  output logic        l_done,
  output logic [15:0] l_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        stall
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  starve_cnt, starve_nxt;
  logic        owner, owner_nxt;       // 0 = pipeline, 1 = loader
  logic        lat_we, lat_we_nxt;
  logic [15:0] lat_addr, lat_addr_nxt;
  logic [15:0] lat_wdata, lat_wdata_nxt;

  logic        p_win;
  logic        l_win;

  // The loader only overrides the pipeline once its wait has saturated.
  assign p_win = p_req && !(l_req && (starve_cnt == LIMIT));
  assign l_win = l_req && !p_win;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= 3'd0;
      owner      <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= 16'd0;
      lat_wdata  <= 16'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      owner      <= owner_nxt;
      lat_we     <= lat_we_nxt;
      lat_addr   <= lat_addr_nxt;
      lat_wdata  <= lat_wdata_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    starve_nxt    = starve_cnt;
    owner_nxt     = owner;
    lat_we_nxt    = lat_we;
    lat_addr_nxt  = lat_addr;
    lat_wdata_nxt = lat_wdata;

    case (state)
      IDLE, COMPLETE: begin
        // Arbitration edge: the starvation count moves on every such edge,
        // whether or not anything is granted.
        if (!l_req || l_win) begin
          starve_nxt = 3'd0;
        end else if (starve_cnt < LIMIT) begin
          starve_nxt = starve_cnt + 3'd1;
        end

        if (p_win) begin
          state_nxt     = ISSUE;
          owner_nxt     = 1'b0;
          lat_we_nxt    = p_we;
          lat_addr_nxt  = p_addr;
          lat_wdata_nxt = p_wdata;
        end else if (l_win) begin
          state_nxt     = ISSUE;
          owner_nxt     = 1'b1;
          lat_we_nxt    = l_we;
          lat_addr_nxt  = l_addr;
          lat_wdata_nxt = l_wdata;
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        state_nxt = COMPLETE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs depend only on the registered state and latched request, so
  // input changes during ISSUE cannot disturb the access in flight.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'd0;
    mem_wdata = 16'd0;
    p_gnt     = 1'b0;
    l_gnt     = 1'b0;
    p_done    = 1'b0;
    l_done    = 1'b0;
    p_rdata   = 16'd0;
    l_rdata   = 16'd0;

    if (state == ISSUE) begin
      mem_en    = 1'b1;
      mem_we    = lat_we;
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
      p_gnt     = !owner;
      l_gnt     = owner;
    end

    if (state == COMPLETE) begin
      p_done = !owner;
      l_done = owner;
      // Stores return zero; mem_rdata may still hold an older read.
      if (!lat_we) begin
        if (owner) begin
          l_rdata = mem_rdata;
        end else begin
          p_rdata = mem_rdata;
        end
      end
    end
  end

  assign stall = p_req & ~p_done;

endmodule
